// File: rtl/stab_pkg.sv
// Shared types, default constants and the correction clamp for the stabilizer servo driver.
package stab_pkg;

    typedef logic [15:0] pulse_us_t;

    localparam int DEF_CENTER_US = 1500;
    localparam int DEF_RANGE_US  = 500;
    localparam int DEF_FRAME_US  = 20000;

    function automatic int clamp_corr(input int corr, input int lim);
        if (corr > lim) begin
            return lim;
        end
        if (corr < -lim) begin
            return -lim;
        end
        return corr;
    endfunction

endpackage

// File: rtl/stab_servo_channel.sv
// One servo channel: target register with clamped proportional correction,
// once-per-frame slew of the applied width, at_target flag and PWM compare.
module stab_servo_channel
    import stab_pkg::*;
#(
    parameter int ANGLE_W   = 8,
    parameter int CENTER_US = DEF_CENTER_US,
    parameter int RANGE_US  = DEF_RANGE_US,
    parameter int GAIN      = 4,
    parameter int SLEW_US   = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               force_center_i,
    input  logic               wrap_i,
    input  pulse_us_t          us_cnt_i,
    input  logic [ANGLE_W-1:0] angle_i,
    output logic               pwm_o,
    output pulse_us_t          pulse_us_o,
    output logic               at_target_o
);

    localparam int CW = ANGLE_W + $clog2(GAIN) + 2;
    localparam logic signed [CW-1:0] GAIN_S = CW'(GAIN);
    localparam logic signed [16:0]   SLEW_S = 17'(SLEW_US);
    localparam pulse_us_t CENTER = pulse_us_t'(CENTER_US);
    localparam pulse_us_t SLEW   = pulse_us_t'(SLEW_US);

    logic signed [CW-1:0] angle_ext;
    logic signed [CW-1:0] corr;
    logic signed [16:0]   diff;
    pulse_us_t            target_q, target_d;
    pulse_us_t            cur_q, cur_d;
    logic                 pwm_q;
    logic                 at_q;

    always_comb begin
        angle_ext = {{(CW-ANGLE_W){angle_i[ANGLE_W-1]}}, angle_i};
        corr      = -(angle_ext * GAIN_S);

        target_d = target_q;
        if (force_center_i) begin
            target_d = CENTER;
        end else if (load_i) begin
            target_d = pulse_us_t'(CENTER_US + clamp_corr(int'(corr), RANGE_US));
        end

        // Slew works from the target registered before this edge, so a sample
        // arriving on the wrap cycle waits for the next boundary.
        diff  = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
        cur_d = cur_q;
        if (wrap_i) begin
            if (diff > SLEW_S) begin
                cur_d = cur_q + SLEW;
            end else if (diff < -SLEW_S) begin
                cur_d = cur_q - SLEW;
            end else begin
                cur_d = target_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= CENTER;
            cur_q    <= CENTER;
            pwm_q    <= 1'b0;
            at_q     <= 1'b1;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            pwm_q    <= (us_cnt_i < cur_q);
            at_q     <= (cur_d == target_d);
        end
    end

    assign pwm_o       = pwm_q;
    assign pulse_us_o  = cur_q;
    assign at_target_o = at_q;

endmodule

// File: rtl/stab_servo_driver.sv
// Multi-channel stabilizer servo driver: shared microsecond timebase and frame
// counter feeding NUM_CH servo channels. Define STAB_FAILSAFE_EN to enable the sample timeout.
module stab_servo_driver
    import stab_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ANGLE_W        = 8,
    parameter int CLK_HZ         = 50_000_000,
    parameter int FRAME_US       = DEF_FRAME_US,
    parameter int CENTER_US      = DEF_CENTER_US,
    parameter int RANGE_US       = DEF_RANGE_US,
    parameter int GAIN           = 4,
    parameter int SLEW_US        = 100,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      angle_valid,
    input  logic [NUM_CH*ANGLE_W-1:0] angle,
    input  logic                      arm,
    output logic [NUM_CH-1:0]         servo_pwm,
    output logic [NUM_CH*16-1:0]      pulse_us,
    output logic [NUM_CH-1:0]         at_target,
    output logic                      frame_start,
    output logic                      fault
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(DIV - 1);
    localparam pulse_us_t     FRAME_MAX = pulse_us_t'(FRAME_US - 1);

    if (TIMEOUT_FRAMES < 1 || (CLK_HZ % 1_000_000) != 0) begin : g_bad_cfg
        $error("stab_servo_driver: bad TIMEOUT_FRAMES or CLK_HZ");
    end

    logic [PW-1:0] presc_q, presc_d;
    pulse_us_t     us_cnt_q, us_cnt_d;
    logic          us_tick;
    logic          wrap;
    logic          frame_start_q;
    logic          force_center;

    always_comb begin
        us_tick  = (presc_q == PRE_MAX);
        wrap     = us_tick && (us_cnt_q == FRAME_MAX);
        presc_d  = us_tick ? '0 : presc_q + 1'b1;
        us_cnt_d = us_cnt_q;
        if (wrap) begin
            us_cnt_d = '0;
        end else if (us_tick) begin
            us_cnt_d = us_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            us_cnt_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            us_cnt_q      <= us_cnt_d;
            frame_start_q <= wrap;
        end
    end

    assign frame_start = frame_start_q;

`ifdef STAB_FAILSAFE_EN
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_FRAMES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_FRAMES - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          fault_q, fault_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        fault_d  = fault_q;
        if (angle_valid) begin
            to_cnt_d = '0;
            fault_d  = 1'b0;
        end else if (wrap && to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            fault_q  <= fault_d;
        end
    end

    // A fresh sample overrides the failsafe on the very cycle it arrives.
    assign fault        = fault_q;
    assign force_center = !arm || (fault_q && !angle_valid);
`else
    assign fault        = 1'b0;
    assign force_center = !arm;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stab_servo_channel #(
            .ANGLE_W  (ANGLE_W),
            .CENTER_US(CENTER_US),
            .RANGE_US (RANGE_US),
            .GAIN     (GAIN),
            .SLEW_US  (SLEW_US)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .load_i        (angle_valid),
            .force_center_i(force_center),
            .wrap_i        (wrap),
            .us_cnt_i      (us_cnt_q),
            .angle_i       (angle[i*ANGLE_W +: ANGLE_W]),
            .pwm_o         (servo_pwm[i]),
            .pulse_us_o    (pulse_us[i*16 +: 16]),
            .at_target_o   (at_target[i])
        );
    end

endmodule

// File: tb/tb_stab_servo_driver.sv
// Directed bench for stab_servo_driver: vector table over frame boundaries plus
// hand-written wrap-collision, mid-pulse reset and failsafe sequences.
module tb_stab_servo_driver;

    localparam int FRAME = 2100;

    logic        clk;
    logic        rst_n;
    logic        angle_valid;
    logic [15:0] angle;
    logic        arm;
    logic [1:0]  servo_pwm;
    logic [31:0] pulse_us;
    logic [1:0]  at_target;
    logic        frame_start;
    logic        fault;

    int n_pass  = 0;
    int n_total = 0;

    stab_servo_driver #(
        .NUM_CH        (2),
        .ANGLE_W       (8),
        .CLK_HZ        (1_000_000),
        .FRAME_US      (FRAME),
        .CENTER_US     (1500),
        .RANGE_US      (500),
        .GAIN          (4),
        .SLEW_US       (100),
        .TIMEOUT_FRAMES(3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .angle_valid(angle_valid),
        .angle      (angle),
        .arm        (arm),
        .servo_pwm  (servo_pwm),
        .pulse_us   (pulse_us),
        .at_target  (at_target),
        .frame_start(frame_start),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               arm;
        logic               av;
        logic signed [7:0]  a0;
        logic signed [7:0]  a1;
        logic [15:0]        p0;
        logic [15:0]        p1;
        logic [1:0]         at;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < FRAME + 10);
        check({name, "_frame_seen"}, 32'(frame_start), 32'd1);
    endtask

    // Starts on a frame_start cycle, ends on the next one.
    task automatic measure_frame(input string name, input int e0, input int e1);
        int len = 0;
        int h0  = 0;
        int h1  = 0;
        do begin
            h0 += int'(servo_pwm[0]);
            h1 += int'(servo_pwm[1]);
            len++;
            @(negedge clk);
        end while (frame_start !== 1'b1 && len < FRAME + 10);
        check({name, "_len"}, 32'(len), 32'(FRAME));
        check({name, "_hi0"}, 32'(h0), 32'(e0));
        check({name, "_hi1"}, 32'(h1), 32'(e1));
    endtask

    initial begin
        int n;
        logic exp_fault;
        logic [15:0] exp_p0, exp_p1;

        vecs[0]  = '{1'b0, 1'b0, 8'sd0,   8'sd0,   16'd1500, 16'd1500, 2'b11};
        vecs[1]  = '{1'b1, 1'b1, 8'sd25,  -8'sd10, 16'd1400, 16'd1540, 2'b11};
        vecs[2]  = '{1'b1, 1'b1, 8'sh80,  -8'sd10, 16'd1500, 16'd1540, 2'b10};
        vecs[3]  = '{1'b1, 1'b1, 8'sh80,  -8'sd10, 16'd1600, 16'd1540, 2'b10};
        vecs[4]  = '{1'b1, 1'b1, 8'sh80,  -8'sd10, 16'd1700, 16'd1540, 2'b10};
        vecs[5]  = '{1'b1, 1'b1, 8'sh80,  -8'sd10, 16'd1800, 16'd1540, 2'b10};
        vecs[6]  = '{1'b1, 1'b1, 8'sh80,  -8'sd10, 16'd1900, 16'd1540, 2'b10};
        vecs[7]  = '{1'b1, 1'b1, 8'sh80,  -8'sd10, 16'd2000, 16'd1540, 2'b11};
        vecs[8]  = '{1'b0, 1'b0, 8'sh80,  -8'sd10, 16'd1900, 16'd1500, 2'b10};
        vecs[9]  = '{1'b0, 1'b0, 8'sh80,  -8'sd10, 16'd1800, 16'd1500, 2'b10};
        vecs[10] = '{1'b0, 1'b0, 8'sh80,  -8'sd10, 16'd1700, 16'd1500, 2'b10};
        vecs[11] = '{1'b0, 1'b0, 8'sh80,  -8'sd10, 16'd1600, 16'd1500, 2'b10};
        vecs[12] = '{1'b0, 1'b0, 8'sh80,  -8'sd10, 16'd1500, 16'd1500, 2'b11};
        vecs[13] = '{1'b1, 1'b1, 8'sd127, 8'sd0,   16'd1400, 16'd1500, 2'b10};
        vecs[14] = '{1'b1, 1'b1, 8'sd127, 8'sd0,   16'd1300, 16'd1500, 2'b10};
        vecs[15] = '{1'b1, 1'b1, 8'sd127, 8'sd0,   16'd1200, 16'd1500, 2'b10};
        vecs[16] = '{1'b1, 1'b1, 8'sd127, 8'sd0,   16'd1100, 16'd1500, 2'b10};
        vecs[17] = '{1'b1, 1'b1, 8'sd127, 8'sd0,   16'd1000, 16'd1500, 2'b11};

        rst_n       = 1'b0;
        angle_valid = 1'b0;
        angle       = '0;
        arm         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm",   32'(servo_pwm),       32'd0);
        check("rst_p0",    32'(pulse_us[15:0]),  32'd1500);
        check("rst_p1",    32'(pulse_us[31:16]), 32'd1500);
        check("rst_at",    32'(at_target),       32'd3);
        check("rst_fs",    32'(frame_start),     32'd0);
        check("rst_fault", 32'(fault),           32'd0);
        rst_n = 1'b1;

        wait_frame("init");
        measure_frame("neutral", 1500, 1500);

        for (int i = 0; i < 18; i++) begin
            arm         = vecs[i].arm;
            angle       = {vecs[i].a1, vecs[i].a0};
            angle_valid = vecs[i].av;
            @(negedge clk);
            angle_valid = 1'b0;
            wait_frame($sformatf("v%0d", i));
            check($sformatf("v%0d_p0", i), 32'(pulse_us[15:0]),  32'(vecs[i].p0));
            check($sformatf("v%0d_p1", i), 32'(pulse_us[31:16]), 32'(vecs[i].p1));
            check($sformatf("v%0d_at", i), 32'(at_target),       32'(vecs[i].at));
        end

        measure_frame("clamped", 1000, 1500);

        // Sample lands on the wrap cycle: boundary keeps old target, next one applies it.
        repeat (FRAME - 1) @(negedge clk);
        arm         = 1'b1;
        angle       = {8'sd0, 8'sd100};
        angle_valid = 1'b1;
        @(negedge clk);
        angle_valid = 1'b0;
        check("coll_fs", 32'(frame_start),    32'd1);
        check("coll_p0", 32'(pulse_us[15:0]), 32'd1000);
        check("coll_at", 32'(at_target),      32'd2);
        wait_frame("coll_next");
        check("coll_next_p0", 32'(pulse_us[15:0]), 32'd1100);
        check("coll_next_at", 32'(at_target),      32'd3);

        // Reset in the middle of a high pulse.
        repeat (500) @(negedge clk);
        check("mid_pwm_high", 32'(servo_pwm[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_pwm_low", 32'(servo_pwm), 32'd0);
        repeat (3) @(negedge clk);
        check("rst2_p0", 32'(pulse_us[15:0]),  32'd1500);
        check("rst2_p1", 32'(pulse_us[31:16]), 32'd1500);
        check("rst2_at", 32'(at_target),       32'd3);
        check("rst2_fs", 32'(frame_start),     32'd0);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < FRAME + 10);
        check("rst2_first_frame", 32'(n), 32'(FRAME));
        measure_frame("rst2", 1500, 1500);

        // Sample timeout: one sample, then three boundaries without one.
        arm         = 1'b1;
        angle       = {-8'sd10, 8'sd25};
        angle_valid = 1'b1;
        @(negedge clk);
        angle_valid = 1'b0;
        wait_frame("fs1");
        check("fs1_p0", 32'(pulse_us[15:0]),  32'd1400);
        check("fs1_p1", 32'(pulse_us[31:16]), 32'd1540);
        wait_frame("fs2");
        check("fs2_fault", 32'(fault), 32'd0);
        wait_frame("fs3");
`ifdef STAB_FAILSAFE_EN
        exp_fault = 1'b1;
        exp_p0    = 16'd1500;
        exp_p1    = 16'd1500;
`else
        exp_fault = 1'b0;
        exp_p0    = 16'd1400;
        exp_p1    = 16'd1540;
`endif
        check("fs3_fault", 32'(fault), 32'(exp_fault));
        wait_frame("fs4");
        check("fs4_p0", 32'(pulse_us[15:0]),  32'(exp_p0));
        check("fs4_p1", 32'(pulse_us[31:16]), 32'(exp_p1));
        check("fs4_at", 32'(at_target),       32'd3);
        angle_valid = 1'b1;
        @(negedge clk);
        angle_valid = 1'b0;
        check("fs_clear_fault", 32'(fault), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
